div3_arbiter: RTL and testbench

Shares one combinational divisible-by-3 datapath (`div3_core`) between `NUM_REQ` requesters. Each requester submits an operand over a valid/ready handshake. A round-robin arbiter grants one requester at a time, and the block registers the operand and the checker's outputs. It returns a tagged result over a single valid/ready response channel. It sits between the number-producing clients and the divisibility checker, so only one checker instance exists in the design.

---
 rtl/div3_pkg.sv | 23 ++
 rtl/div3_core.sv | 26 ++
 rtl/div3_arbiter.sv | 114 +++++++++++
 tb/tb_div3_arbiter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div3_pkg.sv
// Shared types and constants for the divisible-by-3 arbiter slice.
package div3_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EVAL = 2'd1,
      RESP = 2'd2
   } div3_state_t;

   localparam int DIV3_REM_W       = 2;
   localparam int DIV3_DEF_WIDTH   = 32;
   localparam int DIV3_DEF_NUM_REQ = 4;

   // a is a remainder (0..2), b a bit-pair value (0..3); sum is at most 5.
   function automatic logic [DIV3_REM_W-1:0] add_mod3(input logic [DIV3_REM_W-1:0] a,
                                                      input logic [1:0]            b);
      logic [2:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s >= 3'd3) s = s - 3'd3;
      return s[1:0];
   endfunction

endpackage

// File: rtl/div3_core.sv
// Combinational remainder-mod-3 of an unsigned WIDTH-bit operand.
module div3_core import div3_pkg::*; #(
   parameter int WIDTH = DIV3_DEF_WIDTH
) (
   input  logic [WIDTH-1:0]      num,
   output logic [DIV3_REM_W-1:0] rem,
   output logic                  div3
);

   localparam int NP = (WIDTH + 1) / 2;

   logic [2*NP-1:0]       num_x;
   logic [DIV3_REM_W-1:0] acc;

   assign num_x = (2*NP)'(num);

   // 4 == 1 (mod 3): every bit pair contributes its plain value 0..3.
   always_comb begin
      acc = '0;
      for (int p = 0; p < NP; p++) acc = add_mod3(acc, num_x[2*p +: 2]);
   end

   assign rem  = acc;
   assign div3 = (acc == '0);

endmodule

// File: rtl/div3_arbiter.sv
// Round-robin share of one div3_core among NUM_REQ requesters.
// DIV3_ARB_ABS_EN: treat operands as two's-complement and check |op|.
module div3_arbiter import div3_pkg::*; #(
   parameter int NUM_REQ = DIV3_DEF_NUM_REQ,
   parameter int WIDTH   = DIV3_DEF_WIDTH,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_REQ-1:0]       req_valid,
   output logic [NUM_REQ-1:0]       req_ready,
   input  logic [NUM_REQ*WIDTH-1:0] req_num,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [ID_W-1:0]          rsp_id,
   output logic                     rsp_div3,
   output logic [DIV3_REM_W-1:0]    rsp_rem,
   output logic                     busy
);

   localparam int IW = ID_W + 1;

   div3_state_t           state_q;
   logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d, id_q, gnt_id, rsp_id_q;
   logic [WIDTH-1:0]      op_q, gnt_num, core_in;
   logic [IW-1:0]         scan;
   logic                  any_vld;
   logic [DIV3_REM_W-1:0] core_rem, rsp_rem_q;
   logic                  core_div3, rsp_div3_q, rsp_valid_q, busy_q;

   // Scan upward from rr_ptr_q with wrap; first valid requester wins.
   always_comb begin
      any_vld = 1'b0;
      gnt_id  = '0;
      scan    = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         scan = {1'b0, rr_ptr_q} + IW'(k);
         if (scan >= IW'(NUM_REQ)) scan = scan - IW'(NUM_REQ);
         if (!any_vld && req_valid[scan[ID_W-1:0]]) begin
            any_vld = 1'b1;
            gnt_id  = scan[ID_W-1:0];
         end
      end
   end

   always_comb begin
      gnt_num = '0;
      for (int i = 0; i < NUM_REQ; i++)
         if (gnt_id == ID_W'(i)) gnt_num = req_num[i*WIDTH +: WIDTH];
   end

   assign rr_ptr_d = (gnt_id == ID_W'(NUM_REQ-1)) ? '0 : gnt_id + 1'b1;

   always_comb begin
      req_ready = '0;
      if (!rst && state_q == IDLE && any_vld) req_ready[gnt_id] = 1'b1;
   end

`ifdef DIV3_ARB_ABS_EN
   assign core_in = (op_q ^ {WIDTH{op_q[WIDTH-1]}}) + WIDTH'(op_q[WIDTH-1]);
`else
   assign core_in = op_q;
`endif

   div3_core #(.WIDTH(WIDTH)) u_core (
      .num  (core_in),
      .rem  (core_rem),
      .div3 (core_div3)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         rr_ptr_q    <= '0;
         op_q        <= '0;
         id_q        <= '0;
         rsp_id_q    <= '0;
         rsp_rem_q   <= '0;
         rsp_div3_q  <= 1'b0;
         rsp_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (any_vld) begin
               op_q     <= gnt_num;
               id_q     <= gnt_id;
               rr_ptr_q <= rr_ptr_d;
               busy_q   <= 1'b1;
               state_q  <= EVAL;
            end
            EVAL: begin
               rsp_rem_q   <= core_rem;
               rsp_div3_q  <= core_div3;
               rsp_id_q    <= id_q;
               rsp_valid_q <= 1'b1;
               state_q     <= RESP;
            end
            RESP: if (rsp_ready) begin
               rsp_valid_q <= 1'b0;
               busy_q      <= 1'b0;
               state_q     <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_rem   = rsp_rem_q;
   assign rsp_div3  = rsp_div3_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_div3_arbiter.sv
// Directed and scoreboarded checks for div3_arbiter (4 requesters, 32-bit operands).
module tb_div3_arbiter;

   localparam int NUM_REQ = 4;
   localparam int WIDTH   = 32;
   localparam int ID_W    = 2;
   localparam int NOPS    = 10000;
   localparam int LIMIT   = 60000;

`ifdef DIV3_ARB_ABS_EN
   localparam logic [1:0] REM_M3 = 2'd0;
   localparam logic [1:0] REM_M1 = 2'd1;
`else
   localparam logic [1:0] REM_M3 = 2'd1;
   localparam logic [1:0] REM_M1 = 2'd0;
`endif

   logic                     clk, rst;
   logic [NUM_REQ-1:0]       req_valid, req_ready;
   logic [NUM_REQ*WIDTH-1:0] req_num;
   logic                     rsp_valid, rsp_ready, rsp_div3, busy;
   logic [ID_W-1:0]          rsp_id;
   logic [1:0]               rsp_rem;

   int n_vec = 0;
   int n_err = 0;

   div3_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .ID_W(ID_W)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_num(req_num), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_id(rsp_id), .rsp_div3(rsp_div3), .rsp_rem(rsp_rem), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [1:0] ref_rem(input logic [31:0] x);
      logic [31:0] a;
      a = x;
`ifdef DIV3_ARB_ABS_EN
      if (x[31]) a = ~x + 32'd1;
`endif
      return 2'(a % 32'd3);
   endfunction

   function automatic int rr_pick(input int ptr, input logic [NUM_REQ-1:0] m);
      for (int k = 0; k < NUM_REQ; k++)
         if (m[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
      return 0;
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst = 1'b1;
      #2;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1; rsp_ready = 1'b0; req_valid = '1; req_num = '0;
      tick; tick;
      n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL reset_req_ready got %b want 0000", req_ready); end
      n_vec++; if ({rsp_valid, rsp_id, rsp_div3, rsp_rem, busy} !== 7'b0) begin n_err++;
         $display("FAIL reset_outputs got v=%b id=%0d d=%b r=%0d busy=%b want all 0", rsp_valid, rsp_id, rsp_div3, rsp_rem, busy); end
      rst = 1'b0;
      #1;
      n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL reset_first_grant got %b want 0001", req_ready); end
      req_valid = '0;
      #1;
   endtask

   task automatic test_single;
      rsp_ready = 1'b1;
      req_num[2*WIDTH +: WIDTH] = 32'd9;
      req_valid = 4'b0100;
      #1;
      n_vec++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL single_grant got %b want 0100", req_ready); end
      tick; req_valid = '0;
      n_vec++; if ({rsp_valid, busy} !== 2'b01) begin n_err++; $display("FAIL single_eval got v=%b busy=%b want v=0 busy=1", rsp_valid, busy); end
      tick;
      n_vec++; if ({rsp_valid, busy, rsp_id, rsp_div3, rsp_rem} !== {1'b1, 1'b1, 2'd2, 1'b1, 2'd0}) begin n_err++;
         $display("FAIL single_resp got v=%b busy=%b id=%0d d=%b r=%0d want 1 1 2 1 0", rsp_valid, busy, rsp_id, rsp_div3, rsp_rem); end
      tick;
      n_vec++; if ({rsp_valid, busy} !== 2'b00) begin n_err++; $display("FAIL single_idle got v=%b busy=%b want 0 0", rsp_valid, busy); end
   endtask

   task automatic test_rotation;
      logic [31:0] ops [4];
      logic [1:0]  rems [4];
      ops  = '{32'h0, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'd10};
      rems = '{2'd0, 2'd1, REM_M1, 2'd1};
      do_reset;
      rsp_ready = 1'b1;
      for (int i = 0; i < NUM_REQ; i++) req_num[i*WIDTH +: WIDTH] = ops[i];
      req_valid = 4'b1111;
      #1;
      for (int k = 0; k < 5; k++) begin
         n_vec++; if (req_ready !== 4'(1 << (k % 4))) begin n_err++;
            $display("FAIL rot_grant%0d got %b want %b", k, req_ready, 4'(1 << (k % 4))); end
         tick;
         if (k == 4) req_valid = '0;
         tick;
         n_vec++; if ({rsp_valid, rsp_id, rsp_rem, rsp_div3} !== {1'b1, 2'(k % 4), rems[k % 4], rems[k % 4] == 2'd0}) begin n_err++;
            $display("FAIL rot_resp%0d got v=%b id=%0d r=%0d d=%b want id=%0d r=%0d", k, rsp_valid, rsp_id, rsp_rem, rsp_div3, k % 4, rems[k % 4]); end
         tick;
      end
   endtask

   task automatic test_backpressure;
      rsp_ready = 1'b0;
      req_num[1*WIDTH +: WIDTH] = 32'd5;
      req_num[3*WIDTH +: WIDTH] = 32'd7;
      req_valid = 4'b0010;
      #1;
      n_vec++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL bp_grant got %b want 0010", req_ready); end
      tick;
      req_valid = 4'b1000;
      #1;
      n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL bp_eval_ready got %b want 0000", req_ready); end
      tick;
      for (int c = 0; c < 5; c++) begin
         n_vec++; if ({rsp_valid, rsp_id, rsp_rem, rsp_div3, req_ready} !== {1'b1, 2'd1, 2'd2, 1'b0, 4'b0000}) begin n_err++;
            $display("FAIL bp_hold%0d got v=%b id=%0d r=%0d d=%b rdy=%b want 1 1 2 0 0000", c, rsp_valid, rsp_id, rsp_rem, rsp_div3, req_ready); end
         tick;
      end
      rsp_ready = 1'b1;
      #1;
      n_vec++; if ({rsp_valid, req_ready} !== {1'b1, 4'b0000}) begin n_err++;
         $display("FAIL bp_rdy_indep got v=%b rdy=%b want 1 0000", rsp_valid, req_ready); end
      tick;
      n_vec++; if ({rsp_valid, req_ready} !== {1'b0, 4'b1000}) begin n_err++;
         $display("FAIL bp_next_grant got v=%b rdy=%b want 0 1000", rsp_valid, req_ready); end
      tick; req_valid = '0;
      tick;
      n_vec++; if ({rsp_valid, rsp_id, rsp_rem} !== {1'b1, 2'd3, 2'd1}) begin n_err++;
         $display("FAIL bp_second got v=%b id=%0d r=%0d want 1 3 1", rsp_valid, rsp_id, rsp_rem); end
      tick;
   endtask

   task automatic test_drop;
      rsp_ready = 1'b1;
      req_num[2*WIDTH +: WIDTH] = 32'd4;
      req_num[0*WIDTH +: WIDTH] = 32'd6;
      req_valid = 4'b0100;
      tick;
      req_valid = 4'b0001;
      tick;
      n_vec++; if ({rsp_valid, rsp_id, rsp_rem} !== {1'b1, 2'd2, 2'd1}) begin n_err++;
         $display("FAIL drop_owner got v=%b id=%0d r=%0d want 1 2 1", rsp_valid, rsp_id, rsp_rem); end
      req_valid = '0;
      tick;
      for (int c = 0; c < 3; c++) begin
         n_vec++; if ({rsp_valid, busy} !== 2'b00) begin n_err++;
            $display("FAIL drop_quiet%0d got v=%b busy=%b want 0 0", c, rsp_valid, busy); end
         tick;
      end
   endtask

   task automatic test_reset_mid;
      rsp_ready = 1'b1;
      req_num[1*WIDTH +: WIDTH] = 32'd11;
      req_num[3*WIDTH +: WIDTH] = 32'd12;
      req_valid = 4'b0010;
      tick;
      rst = 1'b1;
      #1;
      n_vec++; if ({rsp_valid, rsp_id, rsp_div3, rsp_rem, busy, req_ready} !== 11'b0) begin n_err++;
         $display("FAIL rstmid_clear got v=%b id=%0d d=%b r=%0d busy=%b rdy=%b want all 0", rsp_valid, rsp_id, rsp_div3, rsp_rem, busy, req_ready); end
      req_valid = '0;
      tick;
      rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         tick;
         n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_no_resp%0d got %b want 0", c, rsp_valid); end
      end
      req_valid = 4'b1010;
      #1;
      n_vec++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL rstmid_ptr got %b want 0010", req_ready); end
      tick; req_valid = '0;
      tick;
      n_vec++; if ({rsp_valid, rsp_id, rsp_rem, rsp_div3} !== {1'b1, 2'd1, 2'd2, 1'b0}) begin n_err++;
         $display("FAIL rstmid_after got v=%b id=%0d r=%0d d=%b want 1 1 2 0", rsp_valid, rsp_id, rsp_rem, rsp_div3); end
      tick;
   endtask

   task automatic test_abs;
      rsp_ready = 1'b1;
      req_num[0*WIDTH +: WIDTH] = 32'hFFFF_FFFD;
      req_valid = 4'b0001;
      tick; req_valid = '0;
      tick;
      n_vec++; if ({rsp_valid, rsp_id, rsp_rem, rsp_div3} !== {1'b1, 2'd0, REM_M3, REM_M3 == 2'd0}) begin n_err++;
         $display("FAIL abs_fffffffd got v=%b id=%0d r=%0d d=%b want r=%0d", rsp_valid, rsp_id, rsp_rem, rsp_div3, REM_M3); end
      tick;
   endtask

   task automatic test_random;
      logic [31:0]        ops [NUM_REQ];
      int                 wcnt [NUM_REQ];
      logic [NUM_REQ-1:0] pend, exp_rdy, one;
      logic [1:0]         q_id [$];
      logic [31:0]        q_op [$];
      int ph, ptr, granted, cyc, drop_g, w, worst;
      do_reset;
      one = 1; pend = '0; ph = 0; ptr = 0; granted = 0; cyc = 0; drop_g = -1;
      for (int i = 0; i < NUM_REQ; i++) begin ops[i] = '0; wcnt[i] = 0; end
      while ((granted < NOPS || pend != 0 || q_id.size() != 0) && cyc < LIMIT) begin
         if (drop_g >= 0) begin pend[drop_g] = 1'b0; drop_g = -1; end
         for (int i = 0; i < NUM_REQ; i++) begin
            if (pend[i] && $urandom_range(0, 63) == 0) begin
               pend[i] = 1'b0; wcnt[i] = 0;
            end else if (!pend[i] && granted < NOPS && $urandom_range(0, 2) == 0) begin
               case ($urandom_range(0, 7))
                  0: ops[i] = 32'h0;
                  1: ops[i] = 32'hFFFF_FFFF;
                  2: ops[i] = 32'h8000_0000;
                  3: ops[i] = $urandom_range(0, 20);
                  default: ops[i] = $urandom;
               endcase
               pend[i] = 1'b1; wcnt[i] = 0;
            end
            req_num[i*WIDTH +: WIDTH] = ops[i];
         end
         req_valid = pend;
         rsp_ready = ($urandom_range(0, 9) != 0);
         #1;
         exp_rdy = (ph == 0 && pend != 0) ? (one << rr_pick(ptr, pend)) : '0;
         n_vec++; if (req_ready !== exp_rdy) begin n_err++;
            $display("FAIL rnd_ready cyc=%0d got %b want %b", cyc, req_ready, exp_rdy); end
         n_vec++; if (rsp_valid !== (ph == 2)) begin n_err++;
            $display("FAIL rnd_valid cyc=%0d got %b want %b", cyc, rsp_valid, ph == 2); end
         if (ph == 2 && q_id.size() != 0) begin
            n_vec++; if ({rsp_id, rsp_rem, rsp_div3} !== {q_id[0], ref_rem(q_op[0]), ref_rem(q_op[0]) == 2'd0}) begin n_err++;
               $display("FAIL rnd_result cyc=%0d op=%h got id=%0d r=%0d d=%b want id=%0d r=%0d", cyc, q_op[0], rsp_id, rsp_rem, rsp_div3, q_id[0], ref_rem(q_op[0])); end
         end
         case (ph)
            0: if (pend != 0) begin
               w = rr_pick(ptr, pend);
               q_id.push_back(2'(w)); q_op.push_back(ops[w]);
               ptr = (w + 1) % NUM_REQ; granted++; drop_g = w; ph = 1;
               worst = 0;
               for (int i = 0; i < NUM_REQ; i++)
                  if (pend[i] && i != w) begin wcnt[i]++; if (wcnt[i] > worst) worst = wcnt[i]; end
               wcnt[w] = 0;
               n_vec++; if (worst > NUM_REQ - 1) begin n_err++;
                  $display("FAIL rnd_fairness cyc=%0d wait=%0d want <=%0d", cyc, worst, NUM_REQ - 1); end
            end
            1: ph = 2;
            default: if (rsp_ready) begin
               if (q_id.size() != 0) begin void'(q_id.pop_front()); void'(q_op.pop_front()); end
               ph = 0;
            end
         endcase
         tick;
         cyc++;
      end
      req_valid = '0;
      n_vec++; if (cyc >= LIMIT) begin n_err++; $display("FAIL rnd_timeout got %0d grants want %0d", granted, NOPS); end
   endtask

   initial begin
      rst = 1'b1; req_valid = '0; req_num = '0; rsp_ready = 1'b0;
      test_reset;
      test_single;
      test_rotation;
      test_backpressure;
      test_drop;
      test_reset_mid;
      test_abs;
      test_random;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
